// File: rtl/alu_issue_unit.sv
// ---------------------------------------------------------------------------
// alu_issue_unit
//   Producer side of the ALU interface. Accepts one 32-bit instruction word
//   at a time, reads its operands from a local 16x32 register file and drives
//   the combinational alu. It captures the alu result, writes it back to the
//   register file and presents it on a result channel.
//
//   Handshake semantics (both channels): a transfer happens on a rising clock
//   edge where valid and ready are both high. The producer holds valid and its
//   payload stable until that edge. The consumer may change ready at any time.
//
//   Instruction word: [31:28] op, [27:24] rd, [23:20] rs1, [19:16] rs2,
//                     [15] imm_sel, [14:0] imm (zero-extended)
//
// Ports
//   clk, rst_n                        clock, async active-low reset
//   instr_valid/instr_ready/instr_data   instruction channel
//   alu_input1/alu_input2/alu_operation  operands and opcode to the alu
//   alu_result                        combinational result from the alu
//   result_valid/result_ready         result channel handshake
//   result_data/result_rd/result_err  result payload (data 0 on error)
//   dbg_addr/dbg_data                 combinational register file peek
//
// Sequencing: IDLE (accept) -> ISSUE (alu evaluates, writeback) -> RESP.
// Writeback completes before the next accept, so no forwarding is needed.
// ---------------------------------------------------------------------------
module alu_issue_unit #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int IMM_W    = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr_data,
  output logic [DATA_W-1:0] alu_input1,
  output logic [DATA_W-1:0] alu_input2,
  output logic [3:0]        alu_operation,
  input  logic [DATA_W-1:0] alu_result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [DATA_W-1:0] result_data,
  output logic [3:0]        result_rd,
  output logic              result_err,
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [3:0] OP_MAX = 4'd12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t            state;
  logic [3:0]        op_q;
  logic [3:0]        rd_q;
  logic [DATA_W-1:0] rf [NUM_REGS];

  // Instruction field decode
  logic [3:0]        f_op;
  logic [3:0]        f_rd;
  logic [3:0]        f_rs1;
  logic [3:0]        f_rs2;
  logic              f_imm_sel;
  logic [IMM_W-1:0]  f_imm;
  logic [DATA_W-1:0] rs1_val;
  logic [DATA_W-1:0] rs2_val;
  logic [DATA_W-1:0] imm_ext;

  assign f_op      = instr_data[31:28];
  assign f_rd      = instr_data[27:24];
  assign f_rs1     = instr_data[23:20];
  assign f_rs2     = instr_data[19:16];
  assign f_imm_sel = instr_data[15];
  assign f_imm     = instr_data[14:0];

  // r0 is hardwired to zero on every read port.
  assign rs1_val  = (f_rs1 == 4'd0) ? '0 : rf[f_rs1];
  assign rs2_val  = (f_rs2 == 4'd0) ? '0 : rf[f_rs2];
  assign dbg_data = (dbg_addr == 4'd0) ? '0 : rf[dbg_addr];
  assign imm_ext  = {{(DATA_W-IMM_W){1'b0}}, f_imm};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      instr_ready   <= 1'b1;
      result_valid  <= 1'b0;
      result_data   <= '0;
      result_rd     <= 4'd0;
      result_err    <= 1'b0;
      alu_input1    <= '0;
      alu_input2    <= '0;
      alu_operation <= 4'd0;
      op_q          <= 4'd0;
      rd_q          <= 4'd0;
      for (int i = 0; i < NUM_REGS; i++) begin
        rf[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid && instr_ready) begin
            op_q          <= f_op;
            rd_q          <= f_rd;
            alu_input1    <= rs1_val;
            alu_input2    <= f_imm_sel ? imm_ext : rs2_val;
            // Illegal opcodes are never presented to the alu.
            alu_operation <= (f_op > OP_MAX) ? 4'd0 : f_op;
            instr_ready   <= 1'b0;
            state         <= ISSUE;
          end
        end

        ISSUE: begin
          if (op_q <= OP_MAX) begin
            result_data <= alu_result;
            result_err  <= 1'b0;
            if (rd_q != 4'd0) begin
              rf[rd_q] <= alu_result;
            end
          end else begin
            result_data <= '0;
            result_err  <= 1'b1;
          end
          result_rd    <= rd_q;
          result_valid <= 1'b1;
          state        <= RESP;
        end

        RESP: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            instr_ready  <= 1'b1;
            state        <= IDLE;
          end
        end

        default: begin
          result_valid <= 1'b0;
          instr_ready  <= 1'b1;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule
